// File: rtl/sqrt_pkg.sv
// Shared types and constants for the sqrt core scheduler: operand flags,
// result record, canonical quiet-NaN and the scheduler state encoding.
package sqrt_pkg;
  localparam int MANT_W = 11;
  localparam int EXP_W  = 7;

  typedef struct packed {
    logic nan;
    logic pinf;
    logic ninf;
    logic num;
  } sqrt_flags_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } sqrt_res_t;

  localparam logic              QNAN_SIGN = 1'b1;
  localparam logic [EXP_W-1:0]  QNAN_EXP  = 7'd16;
  localparam logic [MANT_W-1:0] QNAN_MANT = 11'h400;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FLUSH, RESP} sqrt_state_t;
endpackage

// File: rtl/sqrt_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the lowest requesting
// index at or above ptr, wrapping to the lowest requesting index overall.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);
  logic            hi_found;
  logic [ID_W-1:0] hi_id, lo_id;

  // Scan downwards so the last hit in each class is the lowest index.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_id = ID_W'(i);
        if (ID_W'(i) >= ptr) begin
          hi_id    = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    any      = |req;
    grant_id = hi_found ? hi_id : lo_id;
    grant    = any ? (NUM_REQ'(1) << grant_id) : '0;
  end
endmodule

// File: rtl/sqrt_scheduler.sv
// Shares one digit-by-digit sqrt core among NUM_REQ requesters: round-robin
// issue, wait for the final beat, return through a valid/ready port, flush on hang.
module sqrt_scheduler
  import sqrt_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int TIMEOUT = 32,
  localparam int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  sqrt_flags_t [NUM_REQ-1:0]       req_flags,
  input  logic [NUM_REQ-1:0][MANT_W-1:0]  req_mant,
  input  logic [NUM_REQ-1:0][EXP_W-1:0]   req_exp,
  output logic                            core_enable,
  output logic                            core_n_valid,
  output logic                            core_is_nan,
  output logic                            core_is_pinf,
  output logic                            core_is_ninf,
  output logic                            core_is_num,
  output logic [MANT_W-1:0]               core_mant,
  output logic [EXP_W-1:0]                core_exp,
  input  logic                            core_it_valid,
  input  logic                            core_result,
  input  logic                            core_sign,
  input  logic [EXP_W-1:0]                core_exp_out,
  input  logic [MANT_W-1:0]               core_mant_out,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic                            rsp_sign,
  output logic [EXP_W-1:0]                rsp_exp,
  output logic [MANT_W-1:0]               rsp_mant,
  output logic                            rsp_err,
  output logic [3:0]                      rsp_iters
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sqrt_state_t          state, state_nx;
  logic [ID_W-1:0]      ptr, gnt_id;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_any, take, done, tmo;
  logic [CNT_W-1:0]     cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid), .ptr(ptr), .grant(gnt), .grant_id(gnt_id), .any(gnt_any)
  );

  assign req_ready = (state == IDLE && core_enable) ? gnt : '0;
  assign take      = (state == IDLE) && core_enable && gnt_any;
  assign done      = core_it_valid && core_result;
  // cnt holds the number of WAIT cycles already completed
  assign tmo       = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (done) state_nx = RESP;
               else if (tmo) state_nx = FLUSH;
      FLUSH:   state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      cnt          <= '0;
      core_enable  <= 1'b0;
      core_n_valid <= 1'b0;
      core_is_nan  <= 1'b0;
      core_is_pinf <= 1'b0;
      core_is_ninf <= 1'b0;
      core_is_num  <= 1'b0;
      core_mant    <= '0;
      core_exp     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_sign     <= 1'b0;
      rsp_exp      <= '0;
      rsp_mant     <= '0;
      rsp_err      <= 1'b0;
      rsp_iters    <= '0;
    end else begin
      core_enable  <= (state_nx != FLUSH);
      core_n_valid <= (state_nx == ISSUE);
      case (state)
        IDLE: if (take) begin
          ptr          <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          core_is_nan  <= req_flags[gnt_id].nan;
          core_is_pinf <= req_flags[gnt_id].pinf;
          core_is_ninf <= req_flags[gnt_id].ninf;
          core_is_num  <= req_flags[gnt_id].num;
          core_mant    <= req_mant[gnt_id];
          core_exp     <= req_exp[gnt_id];
          rsp_id       <= gnt_id;
        end
        ISSUE: begin
          cnt       <= '0;
          rsp_iters <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (core_it_valid && rsp_iters != 4'hF) rsp_iters <= rsp_iters + 1'b1;
          if (done) begin
            rsp_sign  <= core_sign;
            rsp_exp   <= core_exp_out;
            rsp_mant  <= core_mant_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end
        end
        FLUSH: begin
          rsp_sign  <= QNAN_SIGN;
          rsp_exp   <= QNAN_EXP;
          rsp_mant  <= QNAN_MANT;
          rsp_err   <= 1'b1;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/sqrt_scheduler.md
Name: sqrt_scheduler

Overview:
- Shares one `iterate` digit-by-digit half-precision sqrt core among NUM_REQ requesters.
- Arbitrates round-robin and issues one operand at a time as a single-cycle `n_valid` pulse.
- Waits for the core's final result, ignoring intermediate `it_valid` beats.
- Returns the result with the requester id through a valid/ready response port. A watchdog flushes a hung core via its `enable` input.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 32, maximum WAIT-state cycles before flush (must be >13).
- ID_W, derived localparam: max(1, clog2(NUM_REQ)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_flags  in  4*NUM_REQ  per requester {is_nan, is_pinf, is_ninf, is_num}
- req_mant  in  11*NUM_REQ  per-requester mantissa
- req_exp  in  7*NUM_REQ  per-requester signed unbiased exponent
- core_enable  out  1  drives core enable (low = core flush)
- core_n_valid  out  1  start pulse to core
- core_is_nan / core_is_pinf / core_is_ninf / core_is_num  out  1 each  latched operand flags
- core_mant  out  11  latched operand mantissa
- core_exp  out  7  latched operand exponent (signed)
- core_it_valid  in  1  core progress/result beat
- core_result  in  1  core final-result qualifier
- core_sign  in  1  core result sign
- core_exp_out  in  7  core result exponent (signed)
- core_mant_out  in  11  core result mantissa
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the served requester
- rsp_sign  out  1  result sign
- rsp_exp  out  7  result exponent
- rsp_mant  out  11  result mantissa
- rsp_err  out  1  1 = timeout-flushed result
- rsp_iters  out  4  count of core_it_valid beats seen for this operation

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer 0; cycle counter 0; core_enable 0.
- core_enable is registered. It is 0 during rst and becomes 1 at the first edge after rst deasserts. It is 0 only in FLUSH otherwise.
- A transfer occurs when req_valid[i] and req_ready[i] are both high in the same cycle.
- IDLE:
  - req_ready is combinational: a one-hot grant when core_enable=1 and any req_valid is high.
  - Grant goes to the lowest index >= pointer with req_valid set, wrapping around.
  - On transfer: latch that requester's flags, mantissa, exponent and id; pointer <= (g+1) mod NUM_REQ; go to ISSUE.
- ISSUE: core_n_valid=1 for exactly this one cycle with the latched operands. Clear counter and rsp_iters. Go to WAIT.
- WAIT:
  - core_n_valid=0. The counter increments each cycle.
  - Each core_it_valid increments rsp_iters, saturating at 15.
  - core_it_valid with core_result set: capture core_sign, core_exp_out and core_mant_out; rsp_err=0; go to RESP.
  - Counter reaching TIMEOUT with no result: go to FLUSH.
- FLUSH:
  - core_enable=0 for exactly one cycle.
  - Load rsp_sign=1, rsp_exp=+16, rsp_mant=0x400, rsp_err=1. Go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* fields stable until rsp_ready.
  - On rsp_ready: rsp_valid <= 0; go to IDLE.
  - No req_ready is asserted while in RESP.
- Latency, with the handshake in cycle C:
  - core_n_valid high in cycle C+1.
  - Numeric operand: core final beat in C+13, rsp_valid from C+14, rsp_iters=11.
  - Special operand: core final beat in C+2, rsp_valid from C+3, rsp_iters=1.
- Ignored inputs:
  - core_it_valid/core_result outside WAIT is ignored.
  - req_valid dropping while not granted is legal and is ignored.
- Reset mid-operation: the operation is abandoned and no response is produced. core_enable low during rst flushes the core. The pointer returns to 0.
- The block is a pure pass-through of operand encoding: it does no exponent arithmetic.

Decomposition:
- Shared package sqrt_pkg holds:
  - MANT_W=11 and EXP_W=7.
  - Operand flags struct {nan, pinf, ninf, num}.
  - The canonical quiet-NaN constants (sign 1, exp 16, mant 0x400).
  - State enum {IDLE, ISSUE, WAIT, FLUSH, RESP}.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin one-hot grant from request vector and pointer; combinational).

Test Plan:
- Numeric, req0 mant=0x400 exp=0 flags num=1, core = real `iterate` -> one core_n_valid pulse at C+1; rsp_valid at C+14 with id=0, sign=0, exp=0, mant=0x400, iters=11, err=0.
- Special, req1 is_pinf=1 -> rsp_valid at C+3 with id=1, sign=0, exp=16, mant=0, iters=1.
- Round-robin, NUM_REQ=2, both req_valid held high, rsp_ready=1 -> grant order 0,1,0,1. Never two consecutive grants to one requester while the other waits.
- Backpressure, rsp_ready low for 5 cycles after rsp_valid -> rsp fields stable; req_ready=0 and core_n_valid=0 throughout; next grant only after acceptance.
- Timeout, stub core never asserts core_result, TIMEOUT=16 -> core_enable low exactly one cycle after 16 WAIT cycles; response err=1, sign=1, exp=16, mant=0x400.
- Reset asserted in WAIT cycle 5 -> no rsp_valid; core_enable=0 during rst; after release a req1 request is granted before req0 only if req0 is idle (pointer=0).
